// File: rtl/lzc_pkg.sv
// Shared definitions for the leading-zero normalization controller:
// datapath widths, arbiter FSM states and the round-robin pick helper.
package lzc_pkg;

    localparam int LZC_DATA_W = 32;
    localparam int LZC_CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } lzc_arb_state_t;

    // Round-robin search: start at ptr+1 (mod n_req), wrap, first valid wins.
    // Requester slots at or above n_req are never considered. With no valid
    // request the result is ptr; callers gate the grant with "any valid".
    function automatic logic [1:0] rr_pick(
        input logic [3:0] valid,
        input logic [1:0] ptr,
        input int         n_req
    );
        logic [1:0] pick;
        logic       found;
        int         idx;
        pick  = ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= 4; k++) begin
            if (k <= n_req && !found) begin
                idx = (int'(ptr) + k) % n_req;
                if (valid[idx]) begin
                    pick  = 2'(idx);
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/lzc_norm_arb_lzc32.sv
// LZC32: combinational 32-bit leading-zero counter.
// z is the number of leading zeros (0..31) when az is low; az flags an
// all-zero operand, in which case z is meaningless and reads as 0.
module LZC32 (
    input  logic [31:0] data,
    output logic [4:0]  z,
    output logic        az
);

    logic [7:0] nib_zero;

    // Per-nibble zero flags, most significant nibble at index 7.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_nib
            assign nib_zero[gi] = ~|data[4*gi +: 4];
        end
    endgenerate

    assign az = &nib_zero;

    // Priority scan from the MSB; the first set bit fixes the count.
    always_comb begin
        logic found;
        z     = 5'd0;
        found = 1'b0;
        for (int b = 31; b >= 0; b--) begin
            if (!found && data[b]) begin
                z     = 5'(31 - b);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lzc_norm_arb.sv
// lzc_norm_arb: round-robin front end sharing one LZC32 among up to four
// requesters. Accepts one operand in IDLE, evaluates it in CALC, and holds
// the registered count / normalized operand / zero flag in HOLD until the
// consumer takes it.
module lzc_norm_arb
    import lzc_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*32-1:0]     req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ID_W-1:0]         res_id,
    output logic [LZC_CNT_W-1:0]    res_cnt,
    output logic [LZC_DATA_W-1:0]   res_norm,
    output logic                    res_zero,
    output logic                    busy
);

    lzc_arb_state_t          state;
    logic [ID_W-1:0]         ptr;
    logic [ID_W-1:0]         id_q;
    logic [LZC_DATA_W-1:0]   op_q;

    logic [3:0]              valid_pad;
    logic [LZC_DATA_W-1:0]   data_arr [4];
    logic [1:0]              grant;
    logic [ID_W-1:0]         grant_id;
    logic [LZC_DATA_W-1:0]   sel_data;
    logic                    any_valid;

    logic [4:0]              lzc_z;
    logic                    lzc_az;
    logic [LZC_CNT_W-1:0]    calc_cnt;
    logic [LZC_DATA_W-1:0]   calc_norm;

    // Pad the request vector and operand bus to four slots so the
    // arbiter logic is the same for every legal N_REQ.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pad
            if (gi < N_REQ) begin : g_live
                assign valid_pad[gi] = req_valid[gi];
                assign data_arr[gi]  = req_data[32*gi +: 32];
            end else begin : g_tied
                assign valid_pad[gi] = 1'b0;
                assign data_arr[gi]  = '0;
            end
        end
    endgenerate

    assign any_valid = |req_valid;
    assign grant     = rr_pick(valid_pad, 2'(ptr), N_REQ);
    assign grant_id  = ID_W'(grant);
    assign sel_data  = data_arr[grant];
    assign busy      = (state != IDLE);

    // Accept strobe only in IDLE and only toward the current winner.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = (state == IDLE) && any_valid && (grant == 2'(gi));
        end
    endgenerate

    LZC32 u_lzc (
        .data (op_q),
        .z    (lzc_z),
        .az   (lzc_az)
    );

    // An all-zero operand reports the full width and a zero mantissa.
    assign calc_cnt  = lzc_az ? LZC_CNT_W'(LZC_DATA_W) : {1'b0, lzc_z};
    assign calc_norm = lzc_az ? '0 : (op_q << lzc_z);

    // Arbiter / result FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= ID_W'(N_REQ - 1);
            op_q      <= '0;
            id_q      <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_cnt   <= '0;
            res_norm  <= '0;
            res_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        op_q  <= sel_data;
                        id_q  <= grant_id;
                        ptr   <= grant_id;
                        state <= CALC;
                    end
                end
                CALC: begin
                    res_cnt   <= calc_cnt;
                    res_norm  <= calc_norm;
                    res_zero  <= lzc_az;
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lzc_norm_arb.sv
// Bench for lzc_norm_arb: directed scenarios with literal expectations,
// then randomized traffic, all cross-checked every cycle against a
// transaction-level reference model.
module tb_lzc_norm_arb;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*32-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           res_valid;
    logic           res_ready = 1'b1;
    logic [1:0]     res_id;
    logic [5:0]     res_cnt;
    logic [31:0]    res_norm;
    logic           res_zero;
    logic           busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    lzc_norm_arb #(.N_REQ(N), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_cnt   (res_cnt),
        .res_norm  (res_norm),
        .res_zero  (res_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_clz(input logic [31:0] x);
        int n;
        n = 0;
        for (int b = 31; b >= 0; b--) begin
            if (x[b]) break;
            n++;
        end
        return n;
    endfunction

    function automatic int m_rr(input logic [3:0] v, input int p);
        for (int k = 1; k <= N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    int          m_ph   = 0;   // 0 waiting for operand, 1 computing, 2 result offered
    int          m_ptr  = N - 1;
    logic [31:0] m_op   = '0;
    int          m_id   = 0;
    logic        m_rv   = 1'b0;
    logic [1:0]  m_rid  = '0;
    logic [5:0]  m_cnt  = '0;
    logic [31:0] m_norm = '0;
    logic        m_zero = 1'b0;

    // Per-cycle comparison against the model, then advance the model.
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        int g;
        int c;
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_res_id", res_id, 0);
            chk("rst_res_cnt", res_cnt, 0);
            chk("rst_res_norm", res_norm, 0);
            chk("rst_res_zero", res_zero, 0);
            m_ph = 0; m_ptr = N - 1; m_op = '0; m_id = 0; m_rv = 0;
            m_rid = '0; m_cnt = '0; m_norm = '0; m_zero = 0;
        end else begin
            exp_rdy = '0;
            g = m_rr(req_valid, m_ptr);
            if (m_ph == 0 && g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            chk("busy", busy, (m_ph != 0));
            chk("res_valid", res_valid, m_rv);
            chk("res_id", res_id, m_rid);
            chk("res_cnt", res_cnt, m_cnt);
            chk("res_norm", res_norm, m_norm);
            chk("res_zero", res_zero, m_zero);
            case (m_ph)
                0: if (g >= 0) begin
                    m_op  = req_data[32*g +: 32];
                    m_id  = g;
                    m_ptr = g;
                    m_ph  = 1;
                end
                1: begin
                    c      = m_clz(m_op);
                    m_cnt  = 6'(c);
                    m_norm = (c == 32) ? 32'h0 : (m_op << c);
                    m_zero = (c == 32);
                    m_rid  = 2'(m_id);
                    m_rv   = 1'b1;
                    m_ph   = 2;
                end
                default: if (res_ready) begin
                    $display("tx id=%0d op=%08h cnt=%0d norm=%08h zero=%0b", m_rid, m_op, m_cnt, m_norm, m_zero);
                    m_rv = 1'b0;
                    m_ph = 0;
                end
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(output int g);
        g = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((req_ready & req_valid) != '0) begin
                for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL accept_timeout: got no accept expected accept within 40 cycles");
    endtask

    task automatic do_one(input int i, input logic [31:0] d, input int ecnt,
                          input logic [31:0] enorm, input bit ezero);
        int g;
        step();
        req_valid[i] = 1'b1;
        req_data[32*i +: 32] = d;
        wait_accept(g);
        chk("dir_grant", g, i);
        step();
        req_valid[i] = 1'b0;
        @(negedge clk);
        chk("dir_latency_low", res_valid, 0);
        @(negedge clk);
        chk("dir_res_valid", res_valid, 1);
        chk("dir_res_id", res_id, i);
        chk("dir_res_cnt", res_cnt, ecnt);
        chk("dir_res_norm", res_norm, enorm);
        chk("dir_res_zero", res_zero, ezero);
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 4))
            0: return $urandom;
            1: return $urandom >> $urandom_range(0, 31);
            2: return 32'h0;
            3: return 32'h1 << $urandom_range(0, 31);
            default: return $urandom >> $urandom_range(24, 31);
        endcase
    endfunction

    initial begin
        int g;
        int last;
        logic [N-1:0] acc;

        drain(3);
        rst_n = 1'b1;

        // Basic transaction and boundaries; last one on requester 3 leaves ptr = 3.
        do_one(0, 32'h0000_1000, 19, 32'h8000_0000, 0);
        do_one(0, 32'h8000_0000, 0,  32'h8000_0000, 0);
        do_one(0, 32'h0000_0001, 31, 32'h8000_0000, 0);
        do_one(3, 32'h0000_0000, 32, 32'h0000_0000, 1);

        // All four requesters continuously valid: grants 0,1,2,3,0,1 every 3 cycles.
        step();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b1;
            req_data[32*i +: 32] = 32'h0000_0100 << (4 * i);
        end
        last = 0;
        for (int j = 0; j < 6; j++) begin
            wait_accept(g);
            chk("rr_order", g, j % N);
            if (j > 0) chk("rr_interval", cyc - last, 3);
            last = cyc;
        end
        step();
        req_valid = '0;
        drain(4);

        // Backpressure in HOLD for 5 cycles; ptr is 1, so requester 2 wins, then 3.
        step();
        res_ready = 1'b0;
        req_valid[2] = 1'b1;
        req_data[64 +: 32] = 32'h0000_0F00;
        wait_accept(g);
        chk("stall_grant", g, 2);
        step();
        req_valid[2] = 1'b0;
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        req_data[0 +: 32]  = 32'h0001_0000;
        req_data[96 +: 32] = 32'h0000_0003;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("stall_res_valid", res_valid, 1);
            chk("stall_busy", busy, 1);
            chk("stall_req_ready", req_ready, 0);
            chk("stall_cnt", res_cnt, 20);
            chk("stall_norm", res_norm, 32'hF000_0000);
            if (k < 4) @(negedge clk);
        end
        step();
        res_ready = 1'b1;
        wait_accept(g);
        chk("stall_next_grant", g, 3);
        step();
        req_valid = '0;
        drain(4);

        // Reset during CALC drops the operand; outputs return to reset values at once.
        step();
        req_valid[0] = 1'b1;
        req_data[0 +: 32] = 32'h00F0_0000;
        wait_accept(g);
        chk("rst_grant", g, 0);
        step();
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_res_cnt", res_cnt, 0);
        chk("async_res_id", res_id, 0);
        chk("async_res_norm", res_norm, 0);
        @(negedge clk);
        step();
        rst_n = 1'b1;
        do_one(0, 32'h00F0_0000, 8, 32'hF000_0000, 0);

        // Requester 2 alone, then 1 and 3 together: 3 wins first (ptr+1 = 3).
        step();
        req_valid[2] = 1'b1;
        req_data[64 +: 32] = 32'h4000_0000;
        wait_accept(g);
        chk("pair_first", g, 2);
        step();
        req_valid[2] = 1'b0;
        req_valid[1] = 1'b1;
        req_valid[3] = 1'b1;
        req_data[32 +: 32] = 32'h0000_00FF;
        req_data[96 +: 32] = 32'h0200_0000;
        wait_accept(g);
        chk("pair_second", g, 3);
        step();
        req_valid[3] = 1'b0;
        wait_accept(g);
        chk("pair_third", g, 1);
        step();
        req_valid = '0;
        drain(4);

        // Randomized traffic with random backpressure and occasional withdrawals.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = req_ready & req_valid;
            step();
            for (int i = 0; i < N; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req_valid[i] = 1'b1;
                        req_data[32*i +: 32] = rand_op();
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0;
        res_ready = 1'b1;
        drain(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
